// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

    localparam int unsigned SA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sa_state_t;

endpackage : serial_add_pkg

// File: rtl/serial_add_seq_fa_cell.sv
// One-bit full adder cell shared by the serial sequencer.
module fa_cell (
    input  logic ai,
    input  logic bi,
    input  logic ci,
    output logic so,
    output logic co
);

    assign so = ai ^ bi ^ ci;
    assign co = (ai & bi) | (ai & ci) | (bi & ci);

endmodule : fa_cell

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder cell, LSB first, valid/ready on both sides.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned SW = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [SW-1:0]    sh_s;
    logic             carry;
    logic             s;
    logic             co;

    fa_cell u_fa (
        .ai (sh_a[0]),
        .bi (sh_b[0]),
        .ci (carry),
        .so (s),
        .co (co)
    );

    // Control, datapath shift registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            sum_out     <= '0;
            c_out       <= 1'b0;
            cnt         <= '0;
            sh_a        <= '0;
            sh_b        <= '0;
            sh_s        <= '0;
            carry       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid && start_ready) begin
                        sh_a        <= a_in;
                        sh_b        <= b_in;
                        carry       <= c_in;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_s  <= SW'({s, sh_s} >> 1);
                    carry <= co;
                    // Counter holds at LAST so it never wraps.
                    if (cnt == LAST) begin
                        sum_out    <= {s, sh_s};
                        c_out      <= co;
                        done_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (done_valid && done_ready) begin
                        done_valid  <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    start_ready <= 1'b1;
                    done_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_add_seq
